// File: rtl/ref_clk_pkg.sv
// ----------------------------------------------------------------------------
// ref_clk_pkg
// Shared types and constants for the reference-clock select controller:
//   state_t      - controller FSM states
//   err_cause_t  - recorded cause of the first select error
//   REF_CLK_SEL_DEFAULT / REF_CLK_SEL_MAX - reset select code and largest
//                  legal select code (0..4 = 32/64/128/256/512 division)
//   sel_is_legal - helper telling whether a requested code is in range
// ----------------------------------------------------------------------------
package ref_clk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE       = 2'b00,
    BAD_REQ    = 2'b01,
    MISMATCH   = 2'b10,
    NOT_ONEHOT = 2'b11
  } err_cause_t;

  localparam logic [2:0] REF_CLK_SEL_DEFAULT = 3'd1;
  localparam logic [2:0] REF_CLK_SEL_MAX     = 3'd4;

  function automatic logic sel_is_legal(input logic [2:0] sel);
    return (sel <= REF_CLK_SEL_MAX);
  endfunction

endpackage

// File: rtl/onehot5_encoder.sv
// ----------------------------------------------------------------------------
// onehot5_encoder
// Purely combinational encoder for the 5-bit tgate readback.
//   onehot    (in, 5)  : decoder readback; bit0 = 512 division, bit4 = 32
//   code      (out, 3) : select code of the asserted bit (bit4 -> 0 ... bit0 -> 4)
//   is_onehot (out, 1) : high only when exactly one bit is set
// When the input is not one-hot, code is 0 and must be ignored.
// ----------------------------------------------------------------------------
module onehot5_encoder (
  input  logic [4:0] onehot,
  output logic [2:0] code,
  output logic       is_onehot
);

  // Map each legal one-hot pattern to its select code.
  always_comb begin
    code      = 3'd0;
    is_onehot = 1'b0;
    case (onehot)
      5'b10000: begin code = 3'd0; is_onehot = 1'b1; end
      5'b01000: begin code = 3'd1; is_onehot = 1'b1; end
      5'b00100: begin code = 3'd2; is_onehot = 1'b1; end
      5'b00010: begin code = 3'd3; is_onehot = 1'b1; end
      5'b00001: begin code = 3'd4; is_onehot = 1'b1; end
      default:  begin code = 3'd0; is_onehot = 1'b0; end
    endcase
  end

endmodule

// File: rtl/ref_clk_sel_ctrl.sv
// ----------------------------------------------------------------------------
// ref_clk_sel_ctrl
// Drives the reference-clock division select to the tgate decoder, waits for
// it to settle, then verifies the one-hot readback. The readback is also
// monitored continuously while idle.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   DVDD, DVSS           : local power pins, no logic function
//   wr_valid/wr_sel      : select-change request (held until wr_ready)
//   wr_ready             : high only in IDLE
//   ref_clk_sel          : registered select code to the decoder
//   tgate_control        : one-hot readback from the decoder
//   sel_status           : last verified select code
//   busy                 : a select change is in progress
//   sel_err/err_cause    : sticky error flag and cause of first error
//   err_clr              : clears sel_err/err_cause (a same-cycle error wins)
// Parameter SETTLE_CYCLES (1..15): cycles spent in SETTLE before CHECK.
// ----------------------------------------------------------------------------
module ref_clk_sel_ctrl
  import ref_clk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rstn,
  inout  wire        DVDD,
  inout  wire        DVSS,
  input  logic       wr_valid,
  input  logic [2:0] wr_sel,
  output logic       wr_ready,
  output logic [2:0] ref_clk_sel,
  input  logic [4:0] tgate_control,
  output logic [2:0] sel_status,
  output logic       busy,
  output logic       sel_err,
  output logic [1:0] err_cause,
  input  logic       err_clr
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_r, state_next_s;
  logic [3:0] cnt_r, cnt_next_s;
  logic [2:0] ref_sel_r, ref_sel_next_s;
  logic [2:0] status_r, status_next_s;
  logic       err_r, err_next_s;
  err_cause_t cause_r, cause_next_s;
  logic       wr_ready_r, busy_r;
  logic       first_r;
  logic       bad_req_s;
  logic       chk_en_s, chk_err_s;
  err_cause_t chk_cause_s;
  logic [2:0] enc_code_s;
  logic       enc_onehot_s;

  onehot5_encoder u_enc (
    .onehot    (tgate_control),
    .code      (enc_code_s),
    .is_onehot (enc_onehot_s)
  );

  // Next-state, settle counter and select-code update.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    ref_sel_next_s = ref_sel_r;
    bad_req_s      = 1'b0;
    case (state_r)
      IDLE: begin
        // wr_ready is exactly "state is IDLE", so wr_valid alone accepts here.
        if (wr_valid) begin
          state_next_s = APPLY;
          if (sel_is_legal(wr_sel)) begin
            ref_sel_next_s = wr_sel;
          end else begin
            ref_sel_next_s = REF_CLK_SEL_DEFAULT;
            bad_req_s      = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      APPLY: begin
        state_next_s = SETTLE;
        cnt_next_s   = SETTLE_LOAD;
      end
      SETTLE: begin
        if (cnt_r == 4'd0) begin
          state_next_s = CHECK;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      CHECK: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // Readback check; the very first cycle out of reset is skipped.
  always_comb begin
    chk_en_s      = ((state_r == IDLE) && !first_r) || (state_r == CHECK);
    status_next_s = status_r;
    chk_err_s     = 1'b0;
    chk_cause_s   = NONE;
    if (chk_en_s) begin
      if (!enc_onehot_s) begin
        chk_err_s   = 1'b1;
        chk_cause_s = NOT_ONEHOT;
      end else begin
        status_next_s = enc_code_s;
        if (enc_code_s != ref_sel_r) begin
          chk_err_s   = 1'b1;
          chk_cause_s = MISMATCH;
        end else begin
          chk_err_s   = 1'b0;
        end
      end
    end else begin
      chk_err_s = 1'b0;
    end
  end

  // Sticky error flag; a new error beats a simultaneous clear.
  always_comb begin
    err_next_s   = err_r;
    cause_next_s = cause_r;
    if (bad_req_s || chk_err_s) begin
      err_next_s = 1'b1;
      if (!err_r || err_clr) begin
        cause_next_s = bad_req_s ? BAD_REQ : chk_cause_s;
      end else begin
        cause_next_s = cause_r;
      end
    end else if (err_clr) begin
      err_next_s   = 1'b0;
      cause_next_s = NONE;
    end else begin
      err_next_s   = err_r;
      cause_next_s = cause_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r      <= 4'd0;
      ref_sel_r  <= REF_CLK_SEL_DEFAULT;
      status_r   <= REF_CLK_SEL_DEFAULT;
      err_r      <= 1'b0;
      cause_r    <= NONE;
      wr_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      first_r    <= 1'b1;
    end else begin
      cnt_r      <= cnt_next_s;
      ref_sel_r  <= ref_sel_next_s;
      status_r   <= status_next_s;
      err_r      <= err_next_s;
      cause_r    <= cause_next_s;
      wr_ready_r <= (state_next_s == IDLE);
      busy_r     <= (state_next_s != IDLE);
      first_r    <= 1'b0;
    end
  end

  assign wr_ready    = wr_ready_r;
  assign busy        = busy_r;
  assign ref_clk_sel = ref_sel_r;
  assign sel_status  = status_r;
  assign sel_err     = err_r;
  assign err_cause   = cause_r;

endmodule

// File: tb/tb_ref_clk_sel_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ref_clk_sel_ctrl
// Directed bench for ref_clk_sel_ctrl with a behavioural tgate decoder.
// Each write pushes its expected end-of-transaction state into a queue; a
// monitor pops and compares whenever busy falls (transaction finished or
// aborted). Point checks cover reset values, error flags and clearing.
// ----------------------------------------------------------------------------
module tb_ref_clk_sel_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  wire        dvdd;
  wire        dvss;
  logic       wr_valid;
  logic [2:0] wr_sel;
  logic       wr_ready;
  logic [2:0] ref_clk_sel;
  logic [4:0] tgate_control;
  logic [2:0] sel_status;
  logic       busy;
  logic       sel_err;
  logic [1:0] err_cause;
  logic       err_clr;
  logic       force_en;
  logic [4:0] force_val;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] sel;
    logic [2:0] status;
    logic       err;
    logic [1:0] cause;
    int         busy_cycles;
  } exp_t;

  exp_t sb_q[$];

  assign dvdd = 1'b1;
  assign dvss = 1'b0;

  always #5 clk = ~clk;

  // Behavioural decoder: code 0 -> bit4 (32) ... code 4 -> bit0 (512).
  function automatic logic [4:0] decode(input logic [2:0] s);
    case (s)
      3'd0:    return 5'b10000;
      3'd1:    return 5'b01000;
      3'd2:    return 5'b00100;
      3'd3:    return 5'b00010;
      3'd4:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  assign tgate_control = force_en ? force_val : decode(ref_clk_sel);

  ref_clk_sel_ctrl #(.SETTLE_CYCLES(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .DVDD          (dvdd),
    .DVSS          (dvss),
    .wr_valid      (wr_valid),
    .wr_sel        (wr_sel),
    .wr_ready      (wr_ready),
    .ref_clk_sel   (ref_clk_sel),
    .tgate_control (tgate_control),
    .sel_status    (sel_status),
    .busy          (busy),
    .sel_err       (sel_err),
    .err_cause     (err_cause),
    .err_clr       (err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_txn(input logic [2:0] sel, input logic [2:0] status,
                            input logic err, input logic [1:0] cause, input int bc);
    exp_t e;
    e.sel = sel; e.status = status; e.err = err; e.cause = cause; e.busy_cycles = bc;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; holds the request until accepted, returns one cycle later.
  task automatic do_write(input logic [2:0] sel, input logic [2:0] exp_sel);
    int n = 0;
    wr_valid = 1'b1;
    wr_sel   = sel;
    while (wr_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < 40, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    wr_sel   = 3'd0;
    chk("sel_after_accept", ref_clk_sel, exp_sel);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 40, 1);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Scoreboard monitor: compare whenever busy drops after a busy period.
  initial begin : monitor
    int   cnt;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        cnt++;
      end else if (cnt > 0) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_txn", 0, 1);
        end else begin
          e = sb_q.pop_front();
          chk("txn_ref_clk_sel", ref_clk_sel, e.sel);
          chk("txn_sel_status", sel_status, e.status);
          chk("txn_sel_err", sel_err, e.err);
          chk("txn_err_cause", err_cause, e.cause);
          chk("txn_busy_cycles", cnt, e.busy_cycles);
        end
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    rstn = 1'b1; wr_valid = 1'b0; wr_sel = 3'd0; err_clr = 1'b0;
    force_en = 1'b0; force_val = 5'b00000;
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ref_clk_sel", ref_clk_sel, 1);
    chk("rst_sel_status", sel_status, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_err_cause", err_cause, 0);
    #2 rstn = 1'b1;
    @(negedge clk);

    // Normal write of 4.
    expect_txn(3'd4, 3'd4, 1'b0, 2'd0, 6);
    do_write(3'd4, 3'd4);
    chk("ready_low_while_busy", wr_ready, 0);
    wait_idle();

    // Illegal code 6 coerced to 1 with BAD_REQ.
    expect_txn(3'd1, 3'd1, 1'b1, 2'b01, 6);
    do_write(3'd6, 3'd1);
    chk("bad_req_err", sel_err, 1);
    chk("bad_req_cause", err_cause, 2'b01);
    wait_idle();
    pulse_clr();
    chk("clr_err", sel_err, 0);
    chk("clr_cause", err_cause, 0);

    // Normal write of 3.
    expect_txn(3'd3, 3'd3, 1'b0, 2'd0, 6);
    do_write(3'd3, 3'd3);
    wait_idle();

    // Non-one-hot readback during SETTLE: status keeps 3.
    expect_txn(3'd2, 3'd3, 1'b1, 2'b11, 6);
    do_write(3'd2, 3'd2);
    @(negedge clk);
    force_en = 1'b1; force_val = 5'b00011;
    wait_idle();
    force_en = 1'b0;
    pulse_clr();
    chk("clr2_err", sel_err, 0);
    chk("clr2_cause", err_cause, 0);
    chk("idle_status_update", sel_status, 2);

    // Idle readback change with ref_clk_sel=2 -> mismatch next cycle.
    force_en = 1'b1; force_val = 5'b01000;
    @(negedge clk);
    chk("idle_mm_err", sel_err, 1);
    chk("idle_mm_cause", err_cause, 2'b10);
    chk("idle_mm_status", sel_status, 1);

    // A later error does not overwrite the first cause.
    force_val = 5'b00011;
    @(negedge clk);
    chk("first_cause_kept", err_cause, 2'b10);
    chk("nonhot_status_kept", sel_status, 1);

    // Clear and new error in the same cycle: error wins with the new cause.
    pulse_clr();
    chk("clr_vs_err_flag", sel_err, 1);
    chk("clr_vs_err_cause", err_cause, 2'b11);
    force_en = 1'b0;
    pulse_clr();
    chk("clr3_err", sel_err, 0);
    chk("clr3_cause", err_cause, 0);
    chk("clr3_status", sel_status, 2);

    // Reset during SETTLE of a write of 0 aborts immediately.
    expect_txn(3'd1, 3'd1, 1'b0, 2'd0, 2);
    do_write(3'd0, 3'd0);
    @(negedge clk);
    #2 rstn = 1'b0;
    force_en = 1'b1; force_val = 5'b00011;
    #1;
    chk("abort_ref_clk_sel", ref_clk_sel, 1);
    chk("abort_wr_ready", wr_ready, 1);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("no_check_first_cycle", sel_err, 0);
    chk("post_rst_wr_ready", wr_ready, 1);
    @(negedge clk);
    chk("second_cycle_err", sel_err, 1);
    chk("second_cycle_cause", err_cause, 2'b11);
    force_en = 1'b0;
    pulse_clr();
    chk("clr4_err", sel_err, 0);

    // Same-value write runs the full sequence; next request held while busy.
    expect_txn(3'd1, 3'd1, 1'b0, 2'd0, 6);
    expect_txn(3'd0, 3'd0, 1'b0, 2'd0, 6);
    do_write(3'd1, 3'd1);
    do_write(3'd0, 3'd0);
    wait_idle();

    repeat (2) @(negedge clk);
    chk("sb_all_consumed", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ref_clk_sel_ctrl.md
REF_CLK_SEL_CTRL -- requirements
Module: ref_clk_sel_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles to wait after driving a new select before checking the tgate readback (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports DVDD, DVSS  inout  1  local power, with no logic function.
REQ-005 SHALL have port wr_valid  input  1  select-change request.
REQ-006 SHALL have port wr_sel  input  3  requested select code; legal values 0..4 (32/64/128/256/512 division).
REQ-007 SHALL have port wr_ready  output  1  request may be accepted this cycle.
REQ-008 SHALL have port ref_clk_sel  output  3  registered select code driven to the tgate decoder.
REQ-009 SHALL have port tgate_control  input  5  one-hot readback from the decoder; bit0 = 512 and bit4 = 32.
REQ-010 SHALL have port sel_status  output  3  last verified select, binary-encoded from the readback.
REQ-011 SHALL have port busy  output  1  a select change is in progress.
REQ-012 SHALL have ports sel_err  output  1  sticky error flag, and err_cause  output  2  cause of the first error.
REQ-013 SHALL have port err_clr  input  1  clears sel_err and err_cause.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, SETTLE and CHECK.
REQ-015 SHALL drive wr_ready=1 only in IDLE; a request is accepted when wr_valid && wr_ready; busy = !IDLE.
REQ-016 On acceptance in cycle T, SHALL go to APPLY and update ref_clk_sel so that the new value is visible at T+1.
REQ-017 SHALL coerce wr_sel 5..7 to 3'd1 and raise an error with err_cause=2'b01.
REQ-018 APPLY SHALL last one cycle, then enter SETTLE with the counter loaded to SETTLE_CYCLES-1; SETTLE SHALL decrement the counter and exit to CHECK on 0.
REQ-019 In CHECK, SHALL encode tgate_control as follows: if it is not exactly one-hot, set err_cause=2'b11 and leave sel_status unchanged; else if the encoded value differs from ref_clk_sel, set err_cause=2'b10 and update sel_status; else update sel_status. CHECK SHALL then return to IDLE.
REQ-020 SHALL perform the CHECK comparison every cycle while in IDLE, so that an unexpected readback change raises sel_err.
REQ-021 A write with a value equal to the current ref_clk_sel SHALL still execute the full sequence.
REQ-022 sel_err SHALL be sticky; err_cause SHALL record only the first error after a clear.
REQ-023 When err_clr and a new error occur in the same cycle, the error SHALL win (sel_err=1, err_cause=new cause).
REQ-024 SHALL ignore wr_valid while busy; the requester must hold the request until wr_ready is asserted.
REQ-025 Total latency from acceptance to return to IDLE SHALL be SETTLE_CYCLES+2 cycles.

Reset
REQ-026 While rstn=0, outputs SHALL be: ref_clk_sel=3'd1, sel_status=3'd1, state=IDLE, wr_ready=1, busy=0, sel_err=0, err_cause=0, counter=0.
REQ-027 Reset asserted mid-sequence SHALL abort immediately to the reset values, with no pending request retained.
REQ-028 No error check SHALL occur in the first cycle after reset deassertion.

Structure
REQ-029 Package ref_clk_pkg SHALL hold the FSM state enum, the err_cause enum (NONE/BAD_REQ/MISMATCH/NOT_ONEHOT), REF_CLK_SEL_DEFAULT=3'd1 and REF_CLK_SEL_MAX=3'd4.
REQ-030 SHALL contain one combinational sub-module, onehot5_encoder, with inputs 5-bit and outputs 3-bit code plus an is_onehot flag.

Verification
REQ-031 SHALL be covered by the following scenario: reset, then write wr_sel=4 with the decoder model attached -> ref_clk_sel=4 one cycle after acceptance, busy for 6 cycles, sel_status=4, sel_err=0.
REQ-032 SHALL be covered by the following scenario: write wr_sel=6 -> ref_clk_sel=1, sel_err=1, err_cause=01.
REQ-033 SHALL be covered by the following scenario: force tgate_control=5'b00011 during SETTLE -> at CHECK err_cause=11 and sel_status unchanged.
REQ-034 SHALL be covered by the following scenario: in IDLE with ref_clk_sel=2, force tgate_control=5'b01000 -> sel_err=1 and err_cause=10 the next cycle.
REQ-035 SHALL be covered by the following scenario: pulse err_clr in the same cycle as a mismatch -> sel_err remains 1.
REQ-036 SHALL be covered by the following scenario: assert rstn=0 during SETTLE of a write of 0 -> ref_clk_sel=1 and IDLE immediately; after release wr_ready=1.
